// File: rtl/proc_pkg.sv
// proc_pkg: shared types and field positions for the 9-bit processor control unit
package proc_pkg;

    localparam int WORD_W = 9;

    // Instruction field bit positions within IR
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

endpackage

// File: rtl/proc_control_dec.sv
// dec3to8: 3-bit to one-hot 8 decoder with enable
// Ports:
//   en_i  - when low, output is all zeros
//   sel_i - 3-bit index
//   y_o   - one-hot result, bit sel_i set when enabled
module dec3to8 (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] y_o
);

    assign y_o = en_i ? 8'd1 << sel_i : 8'd0;

endmodule

// File: rtl/proc_control.sv
// proc_control: step sequencer and decoder driving the 9-bit processor datapath
// Ports:
//   clk                 - system clock, rising edge
//   rst                 - synchronous reset, active-low; forces every output to 0
//   Run                 - start request, sampled only in T0
//   IR[8:0]             - instruction from datapath: opcode, Rx, Ry
//   IRin                - load instruction register
//   R0in..R7in          - one-hot register write enables
//   Ain, Gin            - load A, load G
//   R0out..R7out        - register bus-source selects
//   Gout, Dinout        - G and Din bus-source selects
//   AddSub              - 0 add, 1 subtract
//   Done                - one-cycle pulse in an instruction's last step
module proc_control
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Run,
    input  logic [WORD_W-1:0] IR,
    output logic              IRin,
    output logic              R0in,
    output logic              R1in,
    output logic              R2in,
    output logic              R3in,
    output logic              R4in,
    output logic              R5in,
    output logic              R6in,
    output logic              R7in,
    output logic              Ain,
    output logic              Gin,
    output logic              R0out,
    output logic              R1out,
    output logic              R2out,
    output logic              R3out,
    output logic              R4out,
    output logic              R5out,
    output logic              R6out,
    output logic              R7out,
    output logic              Gout,
    output logic              Dinout,
    output logic              AddSub,
    output logic              Done
);

    step_t      step_q, step_d;
    logic [2:0] op, rx, ry, out_sel;
    logic       in_en, out_en, irin, din_sel, a_ld, g_ld, g_sel, sub, done;
    logic [7:0] rin, rout;

    assign op = IR[OP_HI:OP_LO];
    assign rx = IR[RX_HI:RX_LO];
    assign ry = IR[RY_HI:RY_LO];

    always_comb begin
        step_d  = step_q;
        irin    = 1'b0;
        din_sel = 1'b0;
        a_ld    = 1'b0;
        g_ld    = 1'b0;
        g_sel   = 1'b0;
        sub     = 1'b0;
        done    = 1'b0;
        in_en   = 1'b0;
        out_en  = 1'b0;
        out_sel = rx;
        case (step_q)
            T0: begin
                irin    = Run;
                din_sel = Run;
                step_d  = Run ? T1 : T0;
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        out_en  = 1'b1;
                        out_sel = ry;
                        in_en   = 1'b1;
                        done    = 1'b1;
                        step_d  = T0;
                    end
                    OP_MVI: begin
                        din_sel = 1'b1;
                        in_en   = 1'b1;
                        done    = 1'b1;
                        step_d  = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        out_en = 1'b1;
                        a_ld   = 1'b1;
                        step_d = T2;
                    end
                    // Reserved opcodes retire as a one-step NOP
                    default: begin
                        done   = 1'b1;
                        step_d = T0;
                    end
                endcase
            end
            T2: begin
                out_en  = 1'b1;
                out_sel = ry;
                g_ld    = 1'b1;
                sub     = op[0];
                step_d  = T3;
            end
            default: begin
                g_sel  = 1'b1;
                in_en  = 1'b1;
                done   = 1'b1;
                step_d = T0;
            end
        endcase
    end

    // Reset gates both decoder enables so no register is written or driven
    dec3to8 u_dec_in (
        .en_i  (in_en & rst),
        .sel_i (rx),
        .y_o   (rin)
    );

    dec3to8 u_dec_out (
        .en_i  (out_en & rst),
        .sel_i (out_sel),
        .y_o   (rout)
    );

    assign {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in}         = rin;
    assign {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = rout;

    assign IRin   = irin & rst;
    assign Dinout = din_sel & rst;
    assign Ain    = a_ld & rst;
    assign Gin    = g_ld & rst;
    assign Gout   = g_sel & rst;
    assign AddSub = sub & rst;
    assign Done   = done & rst;

    always_ff @(posedge clk) begin
        step_q <= rst ? step_d : T0;
    end

endmodule
